// File: rtl/pool_controller.sv
// pool_controller
//   Avalon-MM accelerator performing 2x2 / stride-2 signed max pooling over
//   per-layer square feature maps held in SDRAM. The CPU programs base
//   addresses and sizes through the slave port, writes CTRL to start, and
//   polls CTRL for done.
//
// Build option:
//   POOL_RELU_EN  defined   -> pooled value is clamped at zero (fused ReLU)
//                 undefined -> raw signed maximum is written
//
// Ports:
//   clk                 system clock
//   reset               synchronous, active-low reset
//   slave_waitrequest   always 0
//   slave_address[2:0]  register word index
//   slave_read          register read strobe
//   slave_readdata[31:0] combinational read data, 0 when not reading
//   slave_write         register write strobe
//   slave_writedata[31:0] register write data
//   master_waitrequest  SDRAM stall
//   master_address[31:0] byte address (word address * 4)
//   master_read         SDRAM read request (registered)
//   master_readdata[31:0] SDRAM read data, valid when read is accepted
//   master_write        SDRAM write request (registered)
//   master_writedata[31:0] SDRAM write data (registered)
//
// Register map: 0 CTRL (wr: start, rd: {done,busy}), 1 IN_BASE, 2 OUT_BASE,
//               3 LAYERS, 4 ROWLEN, 5-7 reserved (read 0).

module pool_controller (
    input  logic        clk,
    input  logic        reset,
    output logic        slave_waitrequest,
    input  logic [2:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;

    logic [31:0] r_in_base,  w_in_base_nxt;
    logic [31:0] r_out_base, w_out_base_nxt;
    logic [31:0] r_layers,   w_layers_nxt;
    logic [31:0] r_rowlen,   w_rowlen_nxt;
    logic        r_busy,     w_busy_nxt;
    logic        r_done,     w_done_nxt;
    logic [1:0]  r_k,        w_k_nxt;
    logic [15:0] r_c,        w_c_nxt;
    logic [15:0] r_r,        w_r_nxt;
    logic [15:0] r_l,        w_l_nxt;
    logic [31:0] r_max,      w_max_nxt;
    logic        r_mread,    w_mread_nxt;
    logic        r_mwrite,   w_mwrite_nxt;
    logic [31:0] r_maddr,    w_maddr_nxt;
    logic [31:0] r_mwdata,   w_mwdata_nxt;

    logic [31:0] w_m;
    logic        w_last_c;
    logic        w_last_r;
    logic        w_last_l;
    logic [31:0] w_max_sel;
    logic [31:0] w_pool_val;

    // Input word address for output (l, r, c); k[1] selects the row offset,
    // k[0] the column offset, matching the (0,0),(0,1),(1,0),(1,1) order.
    function automatic logic [31:0] in_word(
        input logic [31:0] base,
        input logic [31:0] n,
        input logic [15:0] l,
        input logic [15:0] r,
        input logic [15:0] c,
        input logic [1:0]  k
    );
        logic [31:0] row;
        logic [31:0] col;
        row = {15'd0, r, 1'b0} + {31'd0, k[1]};
        col = {15'd0, c, 1'b0} + {31'd0, k[0]};
        return base + {16'd0, l} * n * n + row * n + col;
    endfunction

    function automatic logic [31:0] out_word(
        input logic [31:0] base,
        input logic [31:0] m,
        input logic [15:0] l,
        input logic [15:0] r,
        input logic [15:0] c
    );
        return base + {16'd0, l} * m * m + {16'd0, r} * m + {16'd0, c};
    endfunction

    function automatic logic [31:0] to_byte(input logic [31:0] word);
        return {word[29:0], 2'b00};
    endfunction

    assign w_m      = r_rowlen >> 1;
    assign w_last_c = ({16'd0, r_c} == w_m - 32'd1);
    assign w_last_r = ({16'd0, r_r} == w_m - 32'd1);
    assign w_last_l = ({16'd0, r_l} == r_layers - 32'd1);

    // Running maximum including the word being accepted this cycle.
    assign w_max_sel = ((r_k == 2'd0) || ($signed(master_readdata) > $signed(r_max)))
                       ? master_readdata : r_max;

`ifdef POOL_RELU_EN
    assign w_pool_val = w_max_sel[31] ? '0 : w_max_sel;
`else
    assign w_pool_val = w_max_sel;
`endif

    assign slave_waitrequest = 1'b0;
    assign master_read       = r_mread;
    assign master_write      = r_mwrite;
    assign master_address    = r_maddr;
    assign master_writedata  = r_mwdata;

    // Read data reflects the registers before any same-cycle write.
    always_comb begin
        slave_readdata = '0;
        if (slave_read && reset) begin
            case (slave_address)
                3'd0:    slave_readdata = {30'd0, r_done, r_busy};
                3'd1:    slave_readdata = r_in_base;
                3'd2:    slave_readdata = r_out_base;
                3'd3:    slave_readdata = r_layers;
                3'd4:    slave_readdata = r_rowlen;
                default: slave_readdata = '0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_in_base_nxt  = r_in_base;
        w_out_base_nxt = r_out_base;
        w_layers_nxt   = r_layers;
        w_rowlen_nxt   = r_rowlen;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_k_nxt        = r_k;
        w_c_nxt        = r_c;
        w_r_nxt        = r_r;
        w_l_nxt        = r_l;
        w_max_nxt      = r_max;
        w_mread_nxt    = r_mread;
        w_mwrite_nxt   = r_mwrite;
        w_maddr_nxt    = r_maddr;
        w_mwdata_nxt   = r_mwdata;

        if (slave_write && !r_busy) begin
            case (slave_address)
                3'd1:    w_in_base_nxt  = slave_writedata;
                3'd2:    w_out_base_nxt = slave_writedata;
                3'd3:    w_layers_nxt   = slave_writedata;
                3'd4:    w_rowlen_nxt   = slave_writedata;
                default: ;
            endcase
        end

        case (r_state)
            S_IDLE: begin
                if (slave_write && (slave_address == 3'd0)) begin
                    if ((r_layers == '0) || (w_m == '0)) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b0;
                        w_busy_nxt  = 1'b1;
                        w_k_nxt     = '0;
                        w_c_nxt     = '0;
                        w_r_nxt     = '0;
                        w_l_nxt     = '0;
                        w_state_nxt = S_READ;
                        w_mread_nxt = 1'b1;
                        w_maddr_nxt = to_byte(r_in_base);
                    end
                end
            end

            S_READ: begin
                if (!master_waitrequest) begin
                    w_max_nxt = w_max_sel;
                    if (r_k == 2'd3) begin
                        w_state_nxt  = S_WRITE;
                        w_mread_nxt  = 1'b0;
                        w_mwrite_nxt = 1'b1;
                        w_maddr_nxt  = to_byte(out_word(r_out_base, w_m, r_l, r_r, r_c));
                        w_mwdata_nxt = w_pool_val;
                    end else begin
                        w_k_nxt     = r_k + 2'd1;
                        w_maddr_nxt = to_byte(in_word(r_in_base, r_rowlen, r_l, r_r, r_c,
                                                      r_k + 2'd1));
                    end
                end
            end

            S_WRITE: begin
                if (!master_waitrequest) begin
                    w_mwrite_nxt = 1'b0;
                    if (w_last_c && w_last_r && w_last_l) begin
                        w_busy_nxt   = 1'b0;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = S_IDLE;
                        w_maddr_nxt  = '0;
                        w_mwdata_nxt = '0;
                    end else begin
                        // c fastest, then r, then l.
                        if (w_last_c) begin
                            w_c_nxt = '0;
                            if (w_last_r) begin
                                w_r_nxt = '0;
                                w_l_nxt = r_l + 16'd1;
                            end else begin
                                w_r_nxt = r_r + 16'd1;
                            end
                        end else begin
                            w_c_nxt = r_c + 16'd1;
                        end
                        w_k_nxt     = '0;
                        w_state_nxt = S_READ;
                        w_mread_nxt = 1'b1;
                        w_maddr_nxt = to_byte(in_word(r_in_base, r_rowlen, w_l_nxt, w_r_nxt,
                                                      w_c_nxt, 2'd0));
                    end
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_in_base  <= '0;
            r_out_base <= '0;
            r_layers   <= '0;
            r_rowlen   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_k        <= '0;
            r_c        <= '0;
            r_r        <= '0;
            r_l        <= '0;
            r_max      <= '0;
            r_mread    <= 1'b0;
            r_mwrite   <= 1'b0;
            r_maddr    <= '0;
            r_mwdata   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_base  <= w_in_base_nxt;
            r_out_base <= w_out_base_nxt;
            r_layers   <= w_layers_nxt;
            r_rowlen   <= w_rowlen_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_k        <= w_k_nxt;
            r_c        <= w_c_nxt;
            r_r        <= w_r_nxt;
            r_l        <= w_l_nxt;
            r_max      <= w_max_nxt;
            r_mread    <= w_mread_nxt;
            r_mwrite   <= w_mwrite_nxt;
            r_maddr    <= w_maddr_nxt;
            r_mwdata   <= w_mwdata_nxt;
        end
    end

endmodule
